ones_expander: RTL

// - Inverse of the team's bit-count controller/datapath pair: takes a count N and builds
//   a W-bit thermometer word with exactly N ones, packed from the LSB (e.g. N=3 -> 8'b0000_0111).
// - Serial: one '1' is shifted in per clock. Uses the same s/done start handshake as the
//   bit-count block, so a host FSM can drive either block in the same way.
// - Controller and datapath are in one module.

---
 rtl/ones_expander.sv | 81 ++++++++
 1 files changed

// File: rtl/ones_expander.sv
// Serial thermometer-code generator: builds a W-bit word holding min(count, W) ones from the LSB,
// one bit per clock, behind the same s/done start handshake as the bit-count block.
module ones_expander #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [CW-1:0] count,
    output logic [W-1:0]  result,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [CW-1:0] CountMax = CW'(W);

    state_e        state_q, state_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] count_sat;

    // Oversized requests clamp to a full word rather than being rejected.
    assign count_sat = (count > CountMax) ? CountMax : count;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                result_d = '0;
                cnt_d    = count_sat;
                if (s) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    result_d = {result_q[W-2:0], 1'b1};
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                result_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

endmodule
